// File: rtl/video_mnist_pkg.sv
// Shared constants for the video MNIST pipeline: core identity, Wishbone
// register map and a constant-evaluable ceil(log2) helper.
package video_mnist_pkg;

    localparam logic [31:0] CORE_ID = 32'h527A_0C10;

    localparam int ADR_CORE_ID     = 'h00;
    localparam int ADR_PARAM_TH    = 'h01;
    localparam int ADR_ACTIVE_TH   = 'h02;
    localparam int ADR_FRAME_COUNT = 'h03;
    localparam int ADR_HIST_BASE   = 'h10;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/video_class_popcount.sv
// Registered population count of one class's vote bits; advances only on cke.
module video_class_popcount #(
    parameter int CHANNEL_NUM = 8,
    parameter int COUNT_WIDTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   cke_i,
    input  logic [CHANNEL_NUM-1:0] bits_i,
    output logic [COUNT_WIDTH-1:0] count_o
);

    logic [COUNT_WIDTH-1:0] count_d;
    logic [COUNT_WIDTH-1:0] count_q;

    always_comb begin
        count_d = '0;
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            count_d = count_d + COUNT_WIDTH'(bits_i[i]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (cke_i) begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/video_class_argmax.sv
// Per-pixel argmax over class vote popcounts with a frame-shadowed reject
// threshold, plus a per-frame winner histogram exposed over Wishbone.
module video_class_argmax
    import video_mnist_pkg::*;
#(
    parameter int TUSER_WIDTH   = 1,
    parameter int CLASS_NUM     = 10,
    parameter int CHANNEL_NUM   = 8,
    parameter int NUMBER_WIDTH  = 4,
    parameter int COUNT_WIDTH   = 4,
    parameter int HIST_WIDTH    = 24,
    parameter int WB_ADR_WIDTH  = 8,
    parameter int WB_DAT_WIDTH  = 32,
    parameter int WB_SEL_WIDTH  = WB_DAT_WIDTH / 8,
    parameter int INIT_PARAM_TH = 0
) (
    input  logic                             aresetn,
    input  logic                             aclk,
    input  logic [TUSER_WIDTH-1:0]           s_axi4s_tuser,
    input  logic                             s_axi4s_tlast,
    input  logic [CLASS_NUM*CHANNEL_NUM-1:0] s_axi4s_tbinary,
    input  logic                             s_axi4s_tvalid,
    output logic                             s_axi4s_tready,
    output logic [TUSER_WIDTH-1:0]           m_axi4s_tuser,
    output logic                             m_axi4s_tlast,
    output logic [NUMBER_WIDTH-1:0]          m_axi4s_tnumber,
    output logic [COUNT_WIDTH-1:0]           m_axi4s_tcount,
    output logic                             m_axi4s_tvalid,
    input  logic                             m_axi4s_tready,
    input  logic [WB_ADR_WIDTH-1:0]          s_wb_adr_i,
    input  logic [WB_DAT_WIDTH-1:0]          s_wb_dat_i,
    output logic [WB_DAT_WIDTH-1:0]          s_wb_dat_o,
    input  logic                             s_wb_we_i,
    input  logic [WB_SEL_WIDTH-1:0]          s_wb_sel_i,
    input  logic                             s_wb_stb_i,
    output logic                             s_wb_ack_o
);

    localparam int BIN_W      = CLASS_NUM * CHANNEL_NUM;
    localparam int HIST_IDX_W = clog2(CLASS_NUM + 1);

    logic                    cke;
    logic                    in_fire;
    logic                    out_fire;
    logic [WB_DAT_WIDTH-1:0] th_in;

    logic [WB_DAT_WIDTH-1:0] reg_th_q;
    logic [WB_DAT_WIDTH-1:0] active_th_q;

    logic                    s1_valid_q;
    logic [TUSER_WIDTH-1:0]  s1_user_q;
    logic                    s1_last_q;
    logic [BIN_W-1:0]        s1_bin_q;
    logic [WB_DAT_WIDTH-1:0] s1_th_q;

    logic                    s2_valid_q;
    logic [TUSER_WIDTH-1:0]  s2_user_q;
    logic                    s2_last_q;
    logic [WB_DAT_WIDTH-1:0] s2_th_q;
    logic [COUNT_WIDTH-1:0]  cnt [CLASS_NUM];

    logic [COUNT_WIDTH-1:0]  best_cnt;
    logic [NUMBER_WIDTH-1:0] best_idx;
    logic [NUMBER_WIDTH-1:0] number_d;

    logic                    m_valid_q;
    logic [TUSER_WIDTH-1:0]  m_user_q;
    logic                    m_last_q;
    logic [NUMBER_WIDTH-1:0] m_number_q;
    logic [COUNT_WIDTH-1:0]  m_count_q;

    logic [HIST_WIDTH-1:0]   live_q    [CLASS_NUM+1];
    logic [HIST_WIDTH-1:0]   latched_q [CLASS_NUM+1];
    logic [31:0]             frame_count_q;

    logic [WB_ADR_WIDTH-1:0] hist_off;
    logic                    hist_hit;
    logic                    th_wr;

    assign cke      = ~m_valid_q | m_axi4s_tready;
    assign in_fire  = s_axi4s_tvalid & cke;
    assign out_fire = m_valid_q & m_axi4s_tready;
    assign th_wr    = s_wb_stb_i & s_wb_we_i & (s_wb_adr_i == WB_ADR_WIDTH'(ADR_PARAM_TH));

    // Each beat carries the threshold it is judged against, so beats of the
    // previous frame still in flight keep that frame's threshold.
    assign th_in = s_axi4s_tuser[0] ? reg_th_q : active_th_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            reg_th_q    <= WB_DAT_WIDTH'(INIT_PARAM_TH);
            active_th_q <= WB_DAT_WIDTH'(INIT_PARAM_TH);
        end else begin
            if (in_fire && s_axi4s_tuser[0]) begin
                active_th_q <= reg_th_q;
            end
            if (th_wr) begin
                for (int b = 0; b < WB_SEL_WIDTH; b++) begin
                    if (s_wb_sel_i[b]) begin
                        reg_th_q[b*8 +: 8] <= s_wb_dat_i[b*8 +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s1_valid_q <= 1'b0;
            s1_user_q  <= '0;
            s1_last_q  <= 1'b0;
            s1_bin_q   <= '0;
            s1_th_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_user_q  <= '0;
            s2_last_q  <= 1'b0;
            s2_th_q    <= '0;
        end else if (cke) begin
            s1_valid_q <= s_axi4s_tvalid;
            s1_user_q  <= s_axi4s_tuser;
            s1_last_q  <= s_axi4s_tlast;
            s1_bin_q   <= s_axi4s_tbinary;
            s1_th_q    <= th_in;
            s2_valid_q <= s1_valid_q;
            s2_user_q  <= s1_user_q;
            s2_last_q  <= s1_last_q;
            s2_th_q    <= s1_th_q;
        end
    end

    for (genvar c = 0; c < CLASS_NUM; c++) begin : g_pop
        video_class_popcount #(
            .CHANNEL_NUM (CHANNEL_NUM),
            .COUNT_WIDTH (COUNT_WIDTH)
        ) u_popcount (
            .clk_i   (aclk),
            .rst_ni  (aresetn),
            .cke_i   (cke),
            .bits_i  (s1_bin_q[c*CHANNEL_NUM +: CHANNEL_NUM]),
            .count_o (cnt[c])
        );
    end

    // Strict greater-than keeps the lowest class index on ties.
    always_comb begin
        best_cnt = cnt[0];
        best_idx = '0;
        for (int c = 1; c < CLASS_NUM; c++) begin
            if (cnt[c] > best_cnt) begin
                best_cnt = cnt[c];
                best_idx = NUMBER_WIDTH'(c);
            end
        end
        number_d = (WB_DAT_WIDTH'(best_cnt) < s2_th_q) ? NUMBER_WIDTH'(CLASS_NUM) : best_idx;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_valid_q  <= 1'b0;
            m_user_q   <= '0;
            m_last_q   <= 1'b0;
            m_number_q <= '0;
            m_count_q  <= '0;
        end else if (cke) begin
            m_valid_q  <= s2_valid_q;
            m_user_q   <= s2_user_q;
            m_last_q   <= s2_last_q;
            m_number_q <= number_d;
            m_count_q  <= best_cnt;
        end
    end

    // A frame-start beat snapshots the finished frame and restarts counting at itself.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i <= CLASS_NUM; i++) begin
                live_q[i]    <= '0;
                latched_q[i] <= '0;
            end
            frame_count_q <= '0;
        end else if (out_fire) begin
            if (m_user_q[0]) begin
                for (int i = 0; i <= CLASS_NUM; i++) begin
                    latched_q[i] <= live_q[i];
                    live_q[i]    <= (NUMBER_WIDTH'(i) == m_number_q) ? HIST_WIDTH'(1) : '0;
                end
                frame_count_q <= frame_count_q + 32'd1;
            end else begin
                for (int i = 0; i <= CLASS_NUM; i++) begin
                    if (NUMBER_WIDTH'(i) == m_number_q && live_q[i] != '1) begin
                        live_q[i] <= live_q[i] + HIST_WIDTH'(1);
                    end
                end
            end
        end
    end

    assign hist_off = s_wb_adr_i - WB_ADR_WIDTH'(ADR_HIST_BASE);
    assign hist_hit = (s_wb_adr_i >= WB_ADR_WIDTH'(ADR_HIST_BASE)) &&
                      (hist_off <= WB_ADR_WIDTH'(CLASS_NUM));

    always_comb begin
        s_wb_dat_o = '0;
        if (s_wb_stb_i) begin
            if (s_wb_adr_i == WB_ADR_WIDTH'(ADR_CORE_ID)) begin
                s_wb_dat_o = WB_DAT_WIDTH'(CORE_ID);
            end else if (s_wb_adr_i == WB_ADR_WIDTH'(ADR_PARAM_TH)) begin
                s_wb_dat_o = reg_th_q;
            end else if (s_wb_adr_i == WB_ADR_WIDTH'(ADR_ACTIVE_TH)) begin
                s_wb_dat_o = active_th_q;
            end else if (s_wb_adr_i == WB_ADR_WIDTH'(ADR_FRAME_COUNT)) begin
                s_wb_dat_o = WB_DAT_WIDTH'(frame_count_q);
            end else if (hist_hit) begin
                s_wb_dat_o = WB_DAT_WIDTH'(latched_q[hist_off[HIST_IDX_W-1:0]]);
            end
        end
    end

    assign s_wb_ack_o      = s_wb_stb_i;
    assign s_axi4s_tready  = cke;
    assign m_axi4s_tvalid  = m_valid_q;
    assign m_axi4s_tuser   = m_user_q;
    assign m_axi4s_tlast   = m_last_q;
    assign m_axi4s_tnumber = m_number_q;
    assign m_axi4s_tcount  = m_count_q;

endmodule

// File: tb/tb_video_class_argmax.sv
// Scoreboard bench for video_class_argmax: a negedge monitor models the
// argmax/threshold path and compares every output beat in order.
module tb_video_class_argmax;

    logic        aresetn;
    logic        aclk;
    logic [0:0]  s_axi4s_tuser;
    logic        s_axi4s_tlast;
    logic [79:0] s_axi4s_tbinary;
    logic        s_axi4s_tvalid;
    logic        s_axi4s_tready;
    logic [0:0]  m_axi4s_tuser;
    logic        m_axi4s_tlast;
    logic [3:0]  m_axi4s_tnumber;
    logic [3:0]  m_axi4s_tcount;
    logic        m_axi4s_tvalid;
    logic        m_axi4s_tready;
    logic [7:0]  s_wb_adr_i;
    logic [31:0] s_wb_dat_i;
    logic [31:0] s_wb_dat_o;
    logic        s_wb_we_i;
    logic [3:0]  s_wb_sel_i;
    logic        s_wb_stb_i;
    logic        s_wb_ack_o;

    int          vectorsApplied = 0;
    int          miscompares    = 0;
    logic [9:0]  sbQueue [$];
    logic [31:0] modelRegTh     = 32'd0;
    logic [31:0] modelActiveTh  = 32'd0;
    logic        stallPrev      = 1'b0;
    logic [9:0]  stallSnap      = '0;
    logic        randReady      = 1'b0;

    video_class_argmax dut (
        .aresetn         (aresetn),
        .aclk            (aclk),
        .s_axi4s_tuser   (s_axi4s_tuser),
        .s_axi4s_tlast   (s_axi4s_tlast),
        .s_axi4s_tbinary (s_axi4s_tbinary),
        .s_axi4s_tvalid  (s_axi4s_tvalid),
        .s_axi4s_tready  (s_axi4s_tready),
        .m_axi4s_tuser   (m_axi4s_tuser),
        .m_axi4s_tlast   (m_axi4s_tlast),
        .m_axi4s_tnumber (m_axi4s_tnumber),
        .m_axi4s_tcount  (m_axi4s_tcount),
        .m_axi4s_tvalid  (m_axi4s_tvalid),
        .m_axi4s_tready  (m_axi4s_tready),
        .s_wb_adr_i      (s_wb_adr_i),
        .s_wb_dat_i      (s_wb_dat_i),
        .s_wb_dat_o      (s_wb_dat_o),
        .s_wb_we_i       (s_wb_we_i),
        .s_wb_sel_i      (s_wb_sel_i),
        .s_wb_stb_i      (s_wb_stb_i),
        .s_wb_ack_o      (s_wb_ack_o)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectorsApplied++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [79:0] makeVotes(input int counts [10]);
        logic [79:0] v;
        v = '0;
        for (int c = 0; c < 10; c++) begin
            for (int b = 0; b < 8; b++) begin
                if (b < counts[c]) v[c*8 + b] = 1'b1;
            end
        end
        return v;
    endfunction

    // Reference argmax: lowest index wins ties, count below threshold rejects to 10.
    function automatic logic [7:0] modelResult(input logic [79:0] bin, input logic [31:0] th);
        int cnt;
        int best;
        int idx;
        best = -1;
        idx  = 0;
        for (int c = 0; c < 10; c++) begin
            cnt = 0;
            for (int b = 0; b < 8; b++) cnt += int'(bin[c*8 + b]);
            if (cnt > best) begin
                best = cnt;
                idx  = c;
            end
        end
        if (32'(best) < th) idx = 10;
        return {4'(idx), 4'(best)};
    endfunction

    always @(negedge aclk) begin
        if (!aresetn) begin
            sbQueue.delete();
            modelRegTh    = 32'd0;
            modelActiveTh = 32'd0;
            stallPrev     = 1'b0;
        end else begin
            if (stallPrev) begin
                checkOutput("holdStable", 64'({m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tnumber, m_axi4s_tcount}), 64'(stallSnap));
            end
            if (m_axi4s_tvalid && m_axi4s_tready) begin
                checkOutput("sbNonEmpty", 64'(sbQueue.size() != 0), 64'd1);
                if (sbQueue.size() != 0) begin
                    checkOutput("beat", 64'({m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tnumber, m_axi4s_tcount}),
                                64'(sbQueue.pop_front()));
                end
            end
            stallPrev = m_axi4s_tvalid && !m_axi4s_tready;
            stallSnap = {m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tnumber, m_axi4s_tcount};
            if (s_axi4s_tvalid && s_axi4s_tready) begin
                if (s_axi4s_tuser[0]) modelActiveTh = modelRegTh;
                sbQueue.push_back({s_axi4s_tuser, s_axi4s_tlast, modelResult(s_axi4s_tbinary, modelActiveTh)});
            end
            if (s_wb_stb_i && s_wb_we_i && s_wb_adr_i == 8'h01) begin
                for (int b = 0; b < 4; b++) begin
                    if (s_wb_sel_i[b]) modelRegTh[b*8 +: 8] = s_wb_dat_i[b*8 +: 8];
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge aclk);
            #1;
            m_axi4s_tready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // All tasks below start and end one time unit after a rising edge.
    task automatic applyStimulus(input logic [79:0] bin, input logic user, input logic last);
        bit accepted;
        accepted        = 1'b0;
        s_axi4s_tbinary = bin;
        s_axi4s_tuser   = user;
        s_axi4s_tlast   = last;
        s_axi4s_tvalid  = 1'b1;
        for (int i = 0; i < 1000 && !accepted; i++) begin
            @(negedge aclk);
            accepted = s_axi4s_tready;
        end
        if (!accepted) checkOutput("inReady", 64'(s_axi4s_tready), 64'd1);
        @(posedge aclk);
        #1;
        s_axi4s_tvalid = 1'b0;
    endtask

    task automatic wbWrite(input int adr, input logic [31:0] data, input logic [3:0] sel);
        s_wb_adr_i = 8'(adr);
        s_wb_dat_i = data;
        s_wb_sel_i = sel;
        s_wb_we_i  = 1'b1;
        s_wb_stb_i = 1'b1;
        @(posedge aclk);
        #1;
        s_wb_stb_i = 1'b0;
        s_wb_we_i  = 1'b0;
    endtask

    task automatic wbRead(input int adr, output logic [31:0] data);
        s_wb_adr_i = 8'(adr);
        s_wb_we_i  = 1'b0;
        s_wb_stb_i = 1'b1;
        @(negedge aclk);
        data = s_wb_dat_o;
        @(posedge aclk);
        #1;
        s_wb_stb_i = 1'b0;
    endtask

    task automatic waitDrain(input int bound);
        for (int i = 0; i < bound && sbQueue.size() != 0; i++) @(negedge aclk);
        checkOutput("drained", 64'(sbQueue.size()), 64'd0);
        @(posedge aclk);
        #1;
    endtask

    initial begin
        logic [31:0] rd;
        int          cnts [10];
        logic [79:0] v;

        aresetn         = 1'b0;
        s_axi4s_tuser   = '0;
        s_axi4s_tlast   = 1'b0;
        s_axi4s_tbinary = '0;
        s_axi4s_tvalid  = 1'b0;
        m_axi4s_tready  = 1'b1;
        s_wb_adr_i      = '0;
        s_wb_dat_i      = '0;
        s_wb_we_i       = 1'b0;
        s_wb_sel_i      = '0;
        s_wb_stb_i      = 1'b0;

        @(negedge aclk);
        checkOutput("rstValid", 64'(m_axi4s_tvalid), 64'd0);
        checkOutput("rstOut", 64'({m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tnumber, m_axi4s_tcount}), 64'd0);
        checkOutput("rstWbDat", 64'(s_wb_dat_o), 64'd0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        wbRead('h00, rd);
        checkOutput("coreId", 64'(rd), 64'h527A0C10);
        s_wb_stb_i = 1'b1;
        #1;
        checkOutput("ack", 64'(s_wb_ack_o), 64'd1);
        s_wb_stb_i = 1'b0;
        wbRead('h05, rd);
        checkOutput("undefAdr", 64'(rd), 64'd0);
        wbRead('h01, rd);
        checkOutput("paramThRst", 64'(rd), 64'd0);

        $display("[TB] clear winner and latency");
        cnts = '{2, 2, 2, 8, 2, 2, 2, 2, 2, 2};
        applyStimulus(makeVotes(cnts), 1'b1, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge aclk);
            checkOutput("latency", 64'(m_axi4s_tvalid), 64'(i == 3));
        end
        @(posedge aclk);
        #1;

        $display("[TB] tie goes to lowest class");
        cnts = '{0, 0, 5, 0, 0, 0, 0, 5, 0, 0};
        applyStimulus(makeVotes(cnts), 1'b0, 1'b1);
        waitDrain(50);

        $display("[TB] threshold shadowing");
        cnts = '{1, 1, 1, 5, 1, 1, 1, 1, 1, 1};
        v = makeVotes(cnts);
        applyStimulus(v, 1'b1, 1'b0);
        wbWrite('h01, 32'd6, 4'hF);
        applyStimulus(v, 1'b0, 1'b0);
        wbRead('h02, rd);
        checkOutput("activeThOld", 64'(rd), 64'd0);
        applyStimulus(v, 1'b1, 1'b0);
        waitDrain(50);
        wbRead('h02, rd);
        checkOutput("activeThNew", 64'(rd), 64'd6);
        fork
            applyStimulus(v, 1'b1, 1'b0);
            wbWrite('h01, 32'hFFFF_FF02, 4'b0001);
        join
        applyStimulus(v, 1'b0, 1'b1);
        waitDrain(50);
        wbRead('h01, rd);
        checkOutput("paramThSel", 64'(rd), 64'd2);
        wbRead('h02, rd);
        checkOutput("activeThRace", 64'(rd), 64'd6);
        applyStimulus(v, 1'b1, 1'b0);
        waitDrain(50);

        $display("[TB] random backpressure");
        randReady = 1'b1;
        for (int i = 0; i < 40; i++) begin
            v = {16'($urandom), 32'($urandom), 32'($urandom)};
            applyStimulus(v, 1'(i == 0), 1'($urandom_range(0, 1)));
        end
        waitDrain(1000);
        randReady = 1'b0;
        @(posedge aclk);
        #1;

        $display("[TB] reset with beats in flight");
        cnts = '{0, 0, 0, 0, 7, 0, 0, 0, 0, 0};
        applyStimulus(makeVotes(cnts), 1'b1, 1'b0);
        applyStimulus(makeVotes(cnts), 1'b0, 1'b0);
        aresetn = 1'b0;
        #1;
        checkOutput("rstMidValid", 64'(m_axi4s_tvalid), 64'd0);
        @(posedge aclk);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge aclk);
            checkOutput("noOutAfterRst", 64'(m_axi4s_tvalid), 64'd0);
        end
        @(posedge aclk);
        #1;
        for (int i = 0; i <= 10; i += 5) begin
            wbRead('h10 + i, rd);
            checkOutput("histRst", 64'(rd), 64'd0);
        end
        wbRead('h03, rd);
        checkOutput("frameCntRst", 64'(rd), 64'd0);
        wbRead('h02, rd);
        checkOutput("activeThRst", 64'(rd), 64'd0);

        $display("[TB] full frame histogram");
        cnts = '{0, 0, 0, 0, 0, 3, 0, 0, 0, 0};
        v = makeVotes(cnts);
        for (int i = 0; i < 19200; i++) begin
            applyStimulus(v, 1'(i == 0), 1'((i % 160) == 159));
        end
        applyStimulus(v, 1'b1, 1'b0);
        waitDrain(50);
        wbRead('h15, rd);
        checkOutput("hist5", 64'(rd), 64'd19200);
        wbRead('h10, rd);
        checkOutput("hist0", 64'(rd), 64'd0);
        wbRead('h1A, rd);
        checkOutput("histReject", 64'(rd), 64'd0);
        wbRead('h03, rd);
        checkOutput("frameCount", 64'(rd), 64'd2);

        // Read HIST[5] in the very cycle a new frame-start beat latches it.
        applyStimulus(v, 1'b1, 1'b0);
        @(posedge aclk);
        @(posedge aclk);
        #1;
        s_wb_adr_i = 8'h15;
        s_wb_stb_i = 1'b1;
        @(negedge aclk);
        checkOutput("latchCycleFire", 64'(m_axi4s_tvalid && m_axi4s_tready), 64'd1);
        checkOutput("latchCycleRead", 64'(s_wb_dat_o), 64'd19200);
        @(negedge aclk);
        checkOutput("postLatchRead", 64'(s_wb_dat_o), 64'd1);
        @(posedge aclk);
        #1;
        s_wb_stb_i = 1'b0;
        waitDrain(50);

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
